tmds_channel_decoder: RTL
=========================

Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the HDMI transmit path: takes one TMDS channel's unaligned 10-bit parallel words from the deserializer, one word per I_clk_pixel.
- Drives a bitslip request to the deserializer to find word alignment, then decodes control tokens, TERC4 data-island symbols and 8b video data.
- One instance per channel (0..2); the later sink/video-capture logic consumes the decoded outputs.

Parameters:
- CHANNEL, 0, TMDS channel index 0..2; selects which guard-band code O_guard detects.
- CTRL_RUN, 16, consecutive control tokens required to declare lock.
- SEARCH_WINDOW, 4096, cycles without any control token before a bitslip is issued; must exceed one line period (1650 at 720p).
- SLIP_WAIT, 4, cycles to ignore input after a bitslip pulse.
- LOCK_TIMEOUT, 4096, cycles without a control token while locked before lock is dropped.

Ports:
- I_clk_pixel  in  1  pixel clock; all logic on the rising edge.
- I_reset_n  in  1  asynchronous active-low reset.
- I_word  in  10  raw deserialized word; bit 0 is first on the wire.
- O_bitslip  out  1  one-cycle pulse asking the deserializer to rotate one bit.
- O_locked  out  1  word alignment achieved.
- O_de  out  1  word is neither a control token nor TERC4 (video period).
- O_data  out  8  decoded video byte.
- O_ctrl  out  2  {c1,c0} from the last control token.
- O_is_ctrl  out  1  current word is a control token.
- O_is_terc4  out  1  current word is a TERC4 symbol.
- O_terc4  out  4  decoded TERC4 nibble.
- O_guard  out  1  current word is this channel's video guard band.

Behaviour:
- Reset, asynchronous, low: every output 0, FSM goes to SEARCH, all counters 0. Reset asserted mid-operation aborts immediately; a pending slip is dropped.
- Control tokens: 0x354 gives ctrl 00, 0x0AB gives 01, 0x154 gives 10, 0x2AB gives 11.
- TERC4 codes, in order for nibble 0..F: 29C 263 2E4 2E2 171 11E 18E 13C 2CC 139 19C 2C6 28E 271 163 2C3.
- Guard band: 0x2CC for CHANNEL 0 and 2, 0x133 for CHANNEL 1. 0x2CC is also TERC4 nibble 8, so both flags assert.
- Video decode, q = I_word:
  - If q[9]=1, invert q[7:0].
  - d[0] = q[0].
  - d[i] = q[i]^q[i-1] when q[8]=1, otherwise ~(q[i]^q[i-1]), for i = 1..7.
- Latency: all decode outputs are registered, 1 cycle after I_word.
  - O_data is updated on every word.
  - O_ctrl holds its value until the next control token.
  - O_terc4 updates only on a TERC4 match.
- Alignment-independent outputs: O_de, O_is_ctrl, O_is_terc4 and O_guard are driven whether or not O_locked is set; consumers gate them with O_locked.
- FSM states:
  - SEARCH: run counter counts consecutive control tokens and resets on any non-token. Window counter counts cycles since the last token.
    - run reaches CTRL_RUN: go to LOCKED.
    - window reaches SEARCH_WINDOW-1 with no lock: pulse O_bitslip for one cycle, go to SLIP.
    - Both conditions in the same cycle: lock wins and no slip is issued.
  - SLIP: wait SLIP_WAIT cycles with counters cleared, then return to SEARCH. Slips wrap naturally; after 10 slips the alignment has cycled fully and searching continues indefinitely.
  - LOCKED: O_locked=1. Timeout counter clears on every control token.
    - Counter reaches LOCK_TIMEOUT: O_locked=0 next cycle, return to SEARCH with counters cleared and no immediate slip.
- O_bitslip is never asserted in LOCKED or SLIP.
- Counter widths are $clog2(max+1), saturating; no wrap-around.

Decomposition:
- configPackage gains:
  - TMDS_CTRL_TOKEN[4] constants.
  - TERC4 table as a function terc4_encode(nibble).
  - Guard-band constants.
  - typedef enum logic [1:0] {SEARCH, SLIP, LOCKED} tmds_align_state_t.
- Sub-module tmds_word_decode, purely combinational: word in; is_ctrl, ctrl, is_terc4, terc4, is_guard, data out.
- tmds_channel_decoder holds the output registers and the alignment FSM.

Test Plan:
- Aligned stream, 20×0x354 then video words: O_locked rises 1 cycle after the 16th token. Encoded 0x00, 0xFF and 0xA5 (from a reference encoder) decode to 0x00, 0xFF and 0xA5 with 1-cycle latency, O_de=1.
- Stream rotated by 3 bits, 0x354 repeated in blanking every 858 cycles: exactly 3 O_bitslip pulses, each ≥ SEARCH_WINDOW+SLIP_WAIT apart, the model deserializer rotates on each, then lock.
- All 16 TERC4 codes after lock: O_terc4 = 0..F, O_is_terc4=1, O_de=0. Word 0x2CC on CHANNEL 0 additionally sets O_guard.
- Locked, then 5000 cycles of video with no token: O_locked falls at timeout+1 and no slip is issued until a further SEARCH_WINDOW passes.
- Tokens 0x0AB, 0x154, 0x2AB: O_ctrl = 01, 10, 11, held across following video words.
- Assert I_reset_n=0 mid-SLIP and mid-LOCKED: all outputs are 0 immediately and no O_bitslip pulse appears after release until a full SEARCH_WINDOW.

Source files
------------

// File: rtl/tmds_channel_decoder_pkg.sv
// Shared TMDS code tables and alignment FSM encoding for the channel decoder.
package tmds_channel_decoder_pkg;

  // Index i holds the token that carries {c1,c0} = i.
  localparam logic [3:0][9:0] TMDS_CTRL_TOKEN = {10'h2AB, 10'h154, 10'h0AB, 10'h354};

  localparam logic [9:0] GUARD_VIDEO_CH02 = 10'h2CC;
  localparam logic [9:0] GUARD_VIDEO_CH1  = 10'h133;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    LOCKED
  } tmds_align_state_t;

  function automatic logic [9:0] terc4_encode(input logic [3:0] nibble);
    logic [9:0] code;
    code = 10'h29C;
    case (nibble)
      4'h0: code = 10'h29C;
      4'h1: code = 10'h263;
      4'h2: code = 10'h2E4;
      4'h3: code = 10'h2E2;
      4'h4: code = 10'h171;
      4'h5: code = 10'h11E;
      4'h6: code = 10'h18E;
      4'h7: code = 10'h13C;
      4'h8: code = 10'h2CC;
      4'h9: code = 10'h139;
      4'hA: code = 10'h19C;
      4'hB: code = 10'h2C6;
      4'hC: code = 10'h28E;
      4'hD: code = 10'h271;
      4'hE: code = 10'h163;
      4'hF: code = 10'h2C3;
      default: code = 10'h29C;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational classification and decode of one aligned 10-bit TMDS word.
module tmds_word_decode
  import tmds_channel_decoder_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic [9:0] word,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic       is_terc4,
  output logic [3:0] terc4,
  output logic       is_guard,
  output logic [7:0] data
);

  logic [7:0] q;

  always_comb begin
    is_ctrl  = 1'b0;
    ctrl     = 2'b00;
    is_terc4 = 1'b0;
    terc4    = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (word == TMDS_CTRL_TOKEN[i]) begin
        is_ctrl = 1'b1;
        ctrl    = 2'(i);
      end
    end
    for (int n = 0; n < 16; n++) begin
      if (word == terc4_encode(4'(n))) begin
        is_terc4 = 1'b1;
        terc4    = 4'(n);
      end
    end
    // Channel 1 uses the complementary guard pattern; 0 and 2 share 0x2CC.
    is_guard = (CHANNEL == 1) ? (word == GUARD_VIDEO_CH1) : (word == GUARD_VIDEO_CH02);

    q       = word[9] ? ~word[7:0] : word[7:0];
    data    = 8'h00;
    data[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: bitslip-based word alignment plus registered
// decode of control tokens, TERC4 symbols and 8b video data.
module tmds_channel_decoder
  import tmds_channel_decoder_pkg::*;
#(
  parameter int CHANNEL       = 0,
  parameter int CTRL_RUN      = 16,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_WAIT     = 4,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic       I_clk_pixel,
  input  logic       I_reset_n,
  input  logic [9:0] I_word,
  output logic       O_bitslip,
  output logic       O_locked,
  output logic       O_de,
  output logic [7:0] O_data,
  output logic [1:0] O_ctrl,
  output logic       O_is_ctrl,
  output logic       O_is_terc4,
  output logic [3:0] O_terc4,
  output logic       O_guard
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(LOCK_TIMEOUT);

  logic       dec_is_ctrl;
  logic [1:0] dec_ctrl;
  logic       dec_is_terc4;
  logic [3:0] dec_terc4;
  logic       dec_is_guard;
  logic [7:0] dec_data;

  tmds_word_decode #(
    .CHANNEL(CHANNEL)
  ) u_word_decode (
    .word    (I_word),
    .is_ctrl (dec_is_ctrl),
    .ctrl    (dec_ctrl),
    .is_terc4(dec_is_terc4),
    .terc4   (dec_terc4),
    .is_guard(dec_is_guard),
    .data    (dec_data)
  );

  tmds_align_state_t  state, state_nxt;
  logic [RUN_W-1:0]   run_cnt, run_nxt;
  logic [WIN_W-1:0]   win_cnt, win_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic [TO_W-1:0]    to_cnt, to_nxt;
  logic               slip_req;

  always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state    <= SEARCH;
      run_cnt  <= '0;
      win_cnt  <= '0;
      wait_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      run_cnt  <= run_nxt;
      win_cnt  <= win_nxt;
      wait_cnt <= wait_nxt;
      to_cnt   <= to_nxt;
    end
  end

  // Counters not owned by the current state are held at zero, so every state
  // is entered with clean counters.
  always_comb begin
    state_nxt = state;
    run_nxt   = '0;
    win_nxt   = '0;
    wait_nxt  = '0;
    to_nxt    = '0;
    slip_req  = 1'b0;
    unique case (state)
      SEARCH: begin
        if (dec_is_ctrl && (run_cnt == RUN_LAST)) begin
          state_nxt = LOCKED;
        end else if (win_cnt == WIN_LAST) begin
          slip_req  = 1'b1;
          state_nxt = SLIP;
        end else begin
          run_nxt = dec_is_ctrl ? ((&run_cnt) ? run_cnt : run_cnt + 1'b1) : '0;
          win_nxt = dec_is_ctrl ? '0 : ((&win_cnt) ? win_cnt : win_cnt + 1'b1);
        end
      end
      SLIP: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = SEARCH;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (to_cnt == TO_LIMIT) begin
          state_nxt = SEARCH;
        end else begin
          to_nxt = dec_is_ctrl ? '0 : ((&to_cnt) ? to_cnt : to_cnt + 1'b1);
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  assign O_bitslip = slip_req;
  assign O_locked  = (state == LOCKED);

  // Decode results are registered regardless of lock; ctrl and terc4 hold
  // their last valid value between matching words.
  always_ff @(posedge I_clk_pixel or negedge I_reset_n) begin
    if (!I_reset_n) begin
      O_de       <= 1'b0;
      O_data     <= 8'h00;
      O_ctrl     <= 2'b00;
      O_is_ctrl  <= 1'b0;
      O_is_terc4 <= 1'b0;
      O_terc4    <= 4'h0;
      O_guard    <= 1'b0;
    end else begin
      O_de       <= !dec_is_ctrl && !dec_is_terc4;
      O_data     <= dec_data;
      O_is_ctrl  <= dec_is_ctrl;
      O_is_terc4 <= dec_is_terc4;
      O_guard    <= dec_is_guard;
      if (dec_is_ctrl) begin
        O_ctrl <= dec_ctrl;
      end
      if (dec_is_terc4) begin
        O_terc4 <= dec_terc4;
      end
    end
  end

endmodule
